// File: rtl/pc_stat_ctrl.sv
// Architectural state for the SEQ processor: PC register, one-hot status code,
// fault capture and saturating retirement/cycle counters behind a RUN/STOP FSM.
module pc_stat_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [63:0]          p_ctr_final,
    input  logic                 bad_mem,
    input  logic                 in_error,
    input  logic                 flag_halt,
    input  logic                 bad_mem2,
    input  logic                 step_en,
    output logic [63:0]          p_ctr,
    output logic [3:0]           stat,
    output logic                 running,
    output logic                 done,
    output logic [63:0]          fault_pc,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [CNT_WIDTH-1:0] cycle_cnt
);

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0010;
    localparam logic [3:0] STAT_ADR = 4'b0001;
    localparam logic [3:0] STAT_INS = 4'b0100;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [63:0]            p_ctr_nxt, fault_pc_nxt;
    logic [3:0]             stat_nxt, fault_code;
    logic                   done_nxt, any_fault;
    logic [CNT_WIDTH-1:0]   retired_nxt, cycle_cnt_nxt;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign running   = (state == RUN);
    assign any_fault = bad_mem | in_error | flag_halt | bad_mem2;

    // Fetch faults outrank decode, halt, then data-memory faults.
    always_comb begin
        fault_code = STAT_AOK;
        if (bad_mem)        fault_code = STAT_ADR;
        else if (in_error)  fault_code = STAT_INS;
        else if (flag_halt) fault_code = STAT_HLT;
        else if (bad_mem2)  fault_code = STAT_ADR;
    end

    always_comb begin
        state_nxt     = state;
        p_ctr_nxt     = p_ctr;
        stat_nxt      = stat;
        fault_pc_nxt  = fault_pc;
        retired_nxt   = retired;
        cycle_cnt_nxt = cycle_cnt;
        done_nxt      = 1'b0;
        case (state)
            RUN: begin
                if (step_en) begin
                    cycle_cnt_nxt = sat_inc(cycle_cnt);
                    if (any_fault) begin
                        // The faulting instruction does not retire; PC stays on it.
                        stat_nxt     = fault_code;
                        fault_pc_nxt = p_ctr;
                        state_nxt    = STOP;
                        done_nxt     = 1'b1;
                    end else begin
                        p_ctr_nxt   = p_ctr_final;
                        retired_nxt = sat_inc(retired);
                    end
                end
            end
            STOP: begin
                state_nxt = STOP;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            p_ctr     <= RESET_PC;
            stat      <= STAT_AOK;
            fault_pc  <= 64'd0;
            retired   <= '0;
            cycle_cnt <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            p_ctr     <= p_ctr_nxt;
            stat      <= stat_nxt;
            fault_pc  <= fault_pc_nxt;
            retired   <= retired_nxt;
            cycle_cnt <= cycle_cnt_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: doc/pc_stat_ctrl.md
# pc_stat_ctrl

Architectural state holder for the SEQ processor: owns the program-counter register and the processor status code. Each cycle it takes the next PC and the fault/halt flags produced by the combinational fetch/decode/execute/memory/writeback path, and commits the PC or stops the machine. It feeds `p_ctr` back into fetch and exposes status plus retirement/cycle counters to the test bench, replacing ad-hoc status logic at the top level.

## Interface

Parameters:
- `RESET_PC`, 64'd0: PC value loaded on reset.
- `CNT_WIDTH`, 32: width of `retired` and `cycle_cnt`.

Ports:
- `clock`  in  1: single clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `p_ctr_final`  in  64: next PC from the PC-update stage.
- `bad_mem`  in  1: instruction-fetch address fault.
- `in_error`  in  1: invalid instruction.
- `flag_halt`  in  1: `halt` fetched.
- `bad_mem2`  in  1: data-memory address fault.
- `step_en`  in  1: level run-enable. 0 freezes all state.
- `p_ctr`  out  64: current PC, to fetch.
- `stat`  out  4: one-hot status. 4'b1000 AOK, 4'b0010 HLT, 4'b0001 ADR, 4'b0100 INS.
- `running`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse on entry to STOP.
- `fault_pc`  out  64: PC of the instruction that stopped the machine.
- `retired`  out  CNT_WIDTH: instructions committed.
- `cycle_cnt`  out  CNT_WIDTH: enabled cycles spent in RUN.

## Operation

- Two-state FSM: RUN, STOP. `running` = (state == RUN), decoded from the state register.
- Fault priority, highest first: `bad_mem` → ADR; `in_error` → INS; `flag_halt` → HLT; `bad_mem2` → ADR. Only the highest active flag sets `stat`.
- RUN, `step_en`=1, no flag active:
  - `p_ctr` ← `p_ctr_final`.
  - `retired` +1, `cycle_cnt` +1.
  - `stat` stays AOK.
- RUN, `step_en`=1, any flag active:
  - `stat` ← prioritized code.
  - `fault_pc` ← current `p_ctr`.
  - `p_ctr` held; `retired` not incremented; `cycle_cnt` +1.
  - state ← STOP; `done` ← 1.
- RUN, `step_en`=0: all registers hold. Flags are ignored.
- STOP: all registers hold and inputs are ignored; `done` ← 0. Only `reset` exits STOP.
- Counters saturate at all-ones and never wrap.
- `p_ctr_final` is passed through unmodified at 64 bits. Range checking is left to fetch, which reports it via `bad_mem` on the following cycle.

## Timing

- Reset: on an edge with `reset`=1:
  - state ← RUN, `p_ctr` ← `RESET_PC`, `stat` ← 4'b1000.
  - `fault_pc` ← 0, `retired` ← 0, `cycle_cnt` ← 0, `done` ← 0.
  - `reset` overrides every other input, including active flags and STOP state.
- Flags and `p_ctr_final` are sampled at the rising edge. They must be settled combinational functions of the current `p_ctr`.
- Latency: new `p_ctr` is visible one cycle after the edge that commits it. One instruction per enabled cycle.
- `done` is high for exactly the cycle following the faulting edge. `stat`, `fault_pc` and `running`=0 become visible in that same cycle and persist.
- Simultaneous flags resolve by priority in a single cycle; there is no multi-cycle reporting.
- Flags arriving while `step_en`=0 have no effect until `step_en`=1 at an edge.
- Reset asserted in the same cycle as `done`: the next edge clears `done` and returns to RUN.

## Test plan

- Reset then 3 enabled edges with `p_ctr_final` = `p_ctr`+10, no flags:
  - `p_ctr` = 0 → 10 → 20 → 30.
  - `retired` = 3, `cycle_cnt` = 3, `stat` = 4'b1000, `running` = 1.
- At `p_ctr`=0x28, assert `flag_halt` and `bad_mem2` together:
  - `stat` = 4'b0010, `fault_pc` = 0x28, `p_ctr` stays 0x28.
  - `done` pulses one cycle, `retired` unchanged, `running` = 0.
- Assert `bad_mem` with `in_error`:
  - `stat` = 4'b0001.
- In a separate run, assert `in_error` alone:
  - `stat` = 4'b0100.
- Hold `step_en`=0 for 4 edges with `flag_halt`=1 and varying `p_ctr_final`:
  - All outputs unchanged.
  - Raising `step_en` then stops on HLT at the next edge.
- In STOP, toggle all flags and `p_ctr_final` for 5 cycles:
  - All outputs frozen.
- Assert `reset` for one edge:
  - `p_ctr` = `RESET_PC`, `stat` = 4'b1000, counters 0, `running` = 1.
- With `CNT_WIDTH`=4, run 20 clean instructions:
  - `retired` and `cycle_cnt` saturate at 15.
